// File: rtl/div_unit.sv
// Iterative 64/32-bit integer divider (div/divu/rem/remu and *w forms).
// Radix-2 restoring algorithm, one quotient bit per cycle; divide-by-zero and signed overflow skip CALC.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_signed,
  input  logic        op_word,
  input  logic        op_rem,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [63:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, result_q, result_d;
  logic        word_q, word_d, orem_q, orem_d, qneg_q, qneg_d, rneg_q, rneg_d;

  // operand decode at acceptance
  logic [63:0] a_sx, b_sx, a_ext, b_ext, a_mag, b_mag;
  logic        a_neg, b_neg, div_zero, ovf, accept;

  always_comb begin
    a_sx     = {{32{src1[31]}}, src1[31:0]};
    b_sx     = {{32{src2[31]}}, src2[31:0]};
    a_ext    = op_word ? (op_signed ? a_sx : {32'b0, src1[31:0]}) : src1;
    b_ext    = op_word ? (op_signed ? b_sx : {32'b0, src2[31:0]}) : src2;
    a_neg    = op_signed & a_ext[63];
    b_neg    = op_signed & b_ext[63];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == 64'd0);
    ovf      = op_signed & (b_ext == '1) &
               (op_word ? (src1[31:0] == 32'h8000_0000) : (src1 == 64'h8000_0000_0000_0000));
    accept   = in_valid & (state_q == IDLE) & ~flush;
  end

  // one restoring step; the partial remainder needs a 65th bit before the compare
  logic [64:0] shifted, sub;
  logic        ge;
  always_comb begin
    shifted = {rem_q, quo_q[63]};
    sub     = shifted - {1'b0, dvs_q};
    ge      = shifted >= {1'b0, dvs_q};
  end

  logic [63:0] q_mag, q_s, r_s, pick, fix_res;
  always_comb begin
    q_mag   = word_q ? {32'b0, quo_q[31:0]} : quo_q;
    q_s     = qneg_q ? -q_mag : q_mag;
    r_s     = rneg_q ? -rem_q : rem_q;
    pick    = orem_q ? r_s : q_s;
    fix_res = word_q ? {{32{pick[31]}}, pick[31:0]} : pick;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (div_zero | ovf) ? DONE : CALC;
      CALC: if (cnt_q == 7'd1) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // datapath next values
  always_comb begin
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    word_d   = word_q;
    orem_d   = orem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    case (state_q)
      IDLE: if (accept) begin
        word_d = op_word;
        orem_d = op_rem;
        qneg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
        dvs_d  = b_mag;
        rem_d  = 64'd0;
        // word dividend sits in the top half so both widths shift out from bit 63
        quo_d  = op_word ? {a_mag[31:0], 32'b0} : a_mag;
        cnt_d  = op_word ? 7'd32 : 7'd64;
        if (div_zero) begin
          cnt_d    = 7'd0;
          result_d = op_rem ? (op_word ? a_sx : src1) : '1;
        end else if (ovf) begin
          cnt_d    = 7'd0;
          result_d = op_rem ? 64'd0 : (op_word ? a_sx : src1);
        end
      end
      CALC: begin
        cnt_d = cnt_q - 7'd1;
        rem_d = ge ? sub[63:0] : shifted[63:0];
        quo_d = {quo_q[62:0], ge};
      end
      FIX:     result_d = fix_res;
      default: ;
    endcase
    if (flush) cnt_d = 7'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 7'd0;
      quo_q    <= 64'd0;
      rem_q    <= 64'd0;
      dvs_q    <= 64'd0;
      result_q <= 64'd0;
      word_q   <= 1'b0;
      orem_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      word_q   <= word_d;
      orem_q   <= orem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  // outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected result and output edge,
// monitor pops on every presented result and checks value, latency and stability.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        op_signed = 1'b0, op_word = 1'b0, op_rem = 1'b0;
  logic [63:0] src1 = '0, src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [63:0] result;
  logic        busy;

  div_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_signed(op_signed), .op_word(op_word), .op_rem(op_rem),
    .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, spurious = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  logic        shown = 1'b0;
  logic [63:0] held;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!shown) begin
        if (sb.size() == 0) begin
          spurious++;
          checks++;
          errors++;
          $display("FAIL spurious_out: got out_valid with result %h, expected none", result);
        end else begin
          chk("result", result, sb[0].res);
          chk("latency_edge", 64'(cyc), 64'(sb[0].cyc));
          held  = result;
          shown = 1'b1;
        end
      end else begin
        chk("result_stable", result, held);
      end
      if (out_ready) begin
        if (shown) void'(sb.pop_front());
        shown = 1'b0;
      end
    end
  end

  task automatic issue(input logic s, input logic w, input logic r,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat, input bit push);
    op_signed = s; op_word = w; op_rem = r; src1 = a; src2 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("accepted_busy", {63'b0, busy}, 64'd1);
    if (push) sb.push_back('{exp, cyc + lat});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_result", result, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // signed/unsigned, word/double, remainder sign rules
    issue(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1); wait_idle();
    issue(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1); wait_idle();
    issue(0, 1, 0, 64'hDEAD_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1); wait_idle();
    issue(1, 1, 0, 64'h0000_0000_FFFF_FF9C, 64'h1234_5678_0000_0007, 64'hFFFF_FFFF_FFFF_FFF2, 33, 1); wait_idle();
    issue(1, 1, 1, 64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1); wait_idle();
    issue(0, 0, 0, 64'd1000, 64'd10, 64'd100, 65, 1); wait_idle();
    issue(0, 1, 1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 33, 1); wait_idle();
    issue(1, 0, 1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, 1); wait_idle();
    issue(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1); wait_idle();

    // fast paths: divide by zero and signed overflow
    issue(0, 0, 0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1); wait_idle();
    issue(0, 0, 1, 64'd100, 64'd0, 64'd100, 0, 1); wait_idle();
    issue(0, 1, 1, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0005, 0, 1); wait_idle();
    issue(1, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 1); wait_idle();
    issue(1, 1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 0, 1); wait_idle();

    // backpressure in DONE with a competing request
    out_ready = 1'b0;
    issue(1, 0, 0, 64'd10, 64'd3, 64'd3, 65, 1);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("bp_reach_done", {63'b0, out_valid}, 64'd1);
    end
    for (int i = 0; i < 10; i++) begin
      op_signed = 0; op_word = 0; op_rem = 0; src1 = 64'd50; src2 = 64'd0;
      in_valid = 1'b1;
      chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released_valid", {63'b0, out_valid}, 64'd0);
    chk("bp_released_ready", {63'b0, in_ready}, 64'd1);
    wait_idle();

    // flush at CALC cycle 20
    issue(0, 0, 0, 64'd1000, 64'd3, 64'd0, 65, 0);
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
    chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
    repeat (80) @(posedge clk);
    #1 chk("flush_no_output", 64'(spurious), 64'd0);

    // reset during CALC cycle 5
    issue(0, 0, 0, 64'd999, 64'd7, 64'd0, 65, 0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_result", result, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1, 0, 0, 64'd10, 64'd3, 64'd3, 65, 1); wait_idle();
    repeat (80) @(posedge clk);
    #1 chk("final_no_spurious", 64'(spurious), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
